// File: rtl/modport_router_pkg.sv
// Shared constants and types for the serial packet router.
// Latency: n/a (declarations only).
// Backpressure: n/a; senders consult busy_state before launching a packet.
package modport_router_pkg;

    localparam int NPORTS = 16;
    localparam int ADDR_W = 4;

    // Per-input receive state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } in_state_t;

endpackage

// File: rtl/router_in_port.sv
// Per-input receive FSM: collects the LSB-first destination address and tracks packet framing.
// Latency: request raised combinationally in the cycle the last address bit is on din_i.
// Backpressure: none; an ungranted request discards the rest of the packet (DROP).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   din_i                 serial data for this input
//   valid_n_i, frame_n_i  active-low payload-bit-valid and frame
//   grant_i               arbiter verdict for the request raised this cycle
//   req_o, req_addr_o     request to output req_addr_o (valid while req_o is high)
module router_in_port #(
    parameter int ADDR_W = modport_router_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              din_i,
    input  logic              valid_n_i,
    input  logic              frame_n_i,
    input  logic              grant_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] req_addr_o
);
    import modport_router_pkg::*;

    localparam int CNT_W = $clog2(ADDR_W) + 1;

    in_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_bit;

    // Address bits gathered so far, with the bit currently on din_i merged in.
    // addr_q/cnt_q are zero in IDLE, so this also covers the first address bit.
    assign req_addr_o = addr_q | (ADDR_W'(din_i) << cnt_q);
    assign last_bit   = !frame_n_i && (cnt_q == CNT_W'(ADDR_W - 1));
    assign req_o      = last_bit && ((state_q == IDLE) || (state_q == ADDR));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, ADDR: begin
                if (frame_n_i) begin
                    // Idle line, or frame dropped before the address completed.
                    state_d = IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else if (last_bit) begin
                    state_d = grant_i ? PAYLOAD : DROP;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ADDR;
                    addr_d  = req_addr_o;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            PAYLOAD: begin
                if (frame_n_i) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                // Only the final-bit marker ends a dropped packet.
                if (frame_n_i && !valid_n_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/modport_router.sv
// NPORTS x NPORTS serial packet router with fixed-priority (lowest input wins) arbitration.
// Latency: frameo_n falls 1 cycle after the last address bit; each payload bit appears 1 cycle after input.
// Backpressure: none; requests to a busy output or losing arbitration are dropped.
//
// Ports:
//   clock, reset                     clock, synchronous active-high reset
//   din, valid_n, frame_n            per-input serial data, active-low bit-valid and frame
//   dout, valido_n, frameo_n         per-output registered serial data, bit-valid and frame
//   busy_state                       per-output ownership flag
module modport_router #(
    parameter int NPORTS = modport_router_pkg::NPORTS,
    parameter int ADDR_W = modport_router_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NPORTS-1:0] din,
    input  logic [NPORTS-1:0] valid_n,
    input  logic [NPORTS-1:0] frame_n,
    output logic [NPORTS-1:0] dout,
    output logic [NPORTS-1:0] valido_n,
    output logic [NPORTS-1:0] frameo_n,
    output logic [NPORTS-1:0] busy_state
);
    import modport_router_pkg::*;

    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] gnt;
    logic [ADDR_W-1:0] req_addr [NPORTS];

    logic [NPORTS-1:0] win_vld;
    logic [IDX_W-1:0]  win_idx [NPORTS];

    logic [NPORTS-1:0] busy_q, busy_d;
    logic [NPORTS-1:0] end_q, end_d;        // last bit already on the output; release next cycle
    logic [IDX_W-1:0]  owner_q [NPORTS];
    logic [IDX_W-1:0]  owner_d [NPORTS];
    logic [NPORTS-1:0] dout_q, dout_d;
    logic [NPORTS-1:0] valido_n_q, valido_n_d;
    logic [NPORTS-1:0] frameo_n_q, frameo_n_d;

    for (genvar g = 0; g < NPORTS; g++) begin : g_in
        router_in_port #(
            .ADDR_W (ADDR_W)
        ) u_in (
            .clk_i      (clock),
            .rst_i      (reset),
            .din_i      (din[g]),
            .valid_n_i  (valid_n[g]),
            .frame_n_i  (frame_n[g]),
            .grant_i    (gnt[g]),
            .req_o      (req[g]),
            .req_addr_o (req_addr[g])
        );
    end

    // Arbiter: an output is grantable only while not busy; the lowest requesting
    // index is found first and blocks the rest.
    always_comb begin
        gnt     = '0;
        win_vld = '0;
        for (int d = 0; d < NPORTS; d++) begin
            win_idx[d] = '0;
        end
        for (int d = 0; d < NPORTS; d++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (!win_vld[d] && !busy_q[d] && req[i] && (req_addr[i] == ADDR_W'(d))) begin
                    win_vld[d] = 1'b1;
                    win_idx[d] = IDX_W'(i);
                    gnt[i]     = 1'b1;
                end
            end
        end
    end

    // Output side: forward the owner's bits one cycle late, and hold ownership
    // for one extra cycle after the final bit so it is visible with busy high.
    always_comb begin
        busy_d     = busy_q;
        end_d      = end_q;
        owner_d    = owner_q;
        dout_d     = '0;
        valido_n_d = '1;
        frameo_n_d = '1;
        for (int d = 0; d < NPORTS; d++) begin
            if (busy_q[d]) begin
                if (end_q[d]) begin
                    busy_d[d] = 1'b0;
                    end_d[d]  = 1'b0;
                end else begin
                    if (!valid_n[owner_q[d]]) begin
                        dout_d[d]     = din[owner_q[d]];
                        valido_n_d[d] = 1'b0;
                    end
                    if (frame_n[owner_q[d]]) begin
                        end_d[d] = 1'b1;
                    end else begin
                        frameo_n_d[d] = 1'b0;
                    end
                end
            end else if (win_vld[d]) begin
                busy_d[d]     = 1'b1;
                owner_d[d]    = win_idx[d];
                frameo_n_d[d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q     <= '0;
            end_q      <= '0;
            dout_q     <= '0;
            valido_n_q <= '1;
            frameo_n_q <= '1;
            for (int d = 0; d < NPORTS; d++) begin
                owner_q[d] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            end_q      <= end_d;
            dout_q     <= dout_d;
            valido_n_q <= valido_n_d;
            frameo_n_q <= frameo_n_d;
            for (int d = 0; d < NPORTS; d++) begin
                owner_q[d] <= owner_d[d];
            end
        end
    end

    assign dout       = dout_q;
    assign valido_n   = valido_n_q;
    assign frameo_n   = frameo_n_q;
    assign busy_state = busy_q;

endmodule

// File: tb/tb_modport_router.sv
// Directed-vector bench for modport_router: one table row per clock cycle,
// inputs applied before the edge, outputs compared 1 time unit after it.
module tb_modport_router;
    localparam int N  = 16;
    localparam int AW = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] din, valid_n, frame_n;
    logic [N-1:0] dout, valido_n, frameo_n, busy_state;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic         rst;
        logic [N-1:0] din;
        logic [N-1:0] vn;
        logic [N-1:0] fn;
        logic [N-1:0] e_dout;
        logic [N-1:0] e_vn;
        logic [N-1:0] e_fn;
        logic [N-1:0] e_busy;
        string        tag;
    } vec_t;

    vec_t tbl[$];

    logic [N-1:0] ONES;
    logic [N-1:0] ZERO;

    always #5 clock = ~clock;

    modport_router #(.NPORTS(N), .ADDR_W(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .valid_n    (valid_n),
        .frame_n    (frame_n),
        .dout       (dout),
        .valido_n   (valido_n),
        .frameo_n   (frameo_n),
        .busy_state (busy_state)
    );

    function automatic logic [N-1:0] b(input int p);
        logic [N-1:0] one;
        one = 1;
        return one << p;
    endfunction

    task automatic add(input logic rst, input logic [N-1:0] di, input logic [N-1:0] vn,
                       input logic [N-1:0] fn, input logic [N-1:0] ed, input logic [N-1:0] ev,
                       input logic [N-1:0] ef, input logic [N-1:0] eb, input string tag);
        vec_t v;
        v.rst = rst; v.din = di; v.vn = vn; v.fn = fn;
        v.e_dout = ed; v.e_vn = ev; v.e_fn = ef; v.e_busy = eb; v.tag = tag;
        tbl.push_back(v);
    endtask

    // Quiet inputs, quiet outputs, nothing owned.
    task automatic add_idle(input string tag);
        add(1'b0, ZERO, ONES, ONES, ZERO, ONES, ONES, ZERO, tag);
    endtask

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset   = v.rst;
        din     = v.din;
        valid_n = v.vn;
        frame_n = v.fn;
        @(posedge clock);
        #1;
        chk({v.tag, ".dout"},       dout,       v.e_dout);
        chk({v.tag, ".valido_n"},   valido_n,   v.e_vn);
        chk({v.tag, ".frameo_n"},   frameo_n,   v.e_fn);
        chk({v.tag, ".busy_state"}, busy_state, v.e_busy);
    endtask

    // Safety net: the run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] m;
        vec_t         v;

        ONES = '1;
        ZERO = '0;
        reset = 1'b1; din = '0; valid_n = '1; frame_n = '1;

        // Reset held two cycles.
        add(1'b1, ZERO, ONES, ONES, ZERO, ONES, ONES, ZERO, "rst0");
        add(1'b1, ZERO, ONES, ONES, ZERO, ONES, ONES, ZERO, "rst1");
        add_idle("post_rst");

        // Input 3 -> output 5 (addr bits 1,0,1,0), payload 1,0,1,1.
        // valid_n low during an address cycle must be ignored.
        add(1'b0, b(3), ONES,  ~b(3), ZERO, ONES, ONES, ZERO, "sp_a0");
        add(1'b0, ZERO, ~b(3), ~b(3), ZERO, ONES, ONES, ZERO, "sp_a1");
        add(1'b0, b(3), ONES,  ~b(3), ZERO, ONES, ONES, ZERO, "sp_a2");
        add(1'b0, ZERO, ONES,  ~b(3), ZERO, ONES, ~b(5), b(5), "sp_a3");
        add(1'b0, b(3), ~b(3), ~b(3), b(5), ~b(5), ~b(5), b(5), "sp_p0");
        add(1'b0, ZERO, ~b(3), ~b(3), ZERO, ~b(5), ~b(5), b(5), "sp_p1");
        add(1'b0, b(3), ~b(3), ~b(3), b(5), ~b(5), ~b(5), b(5), "sp_p2");
        add(1'b0, b(3), ~b(3), ONES,  b(5), ~b(5), ONES,  b(5), "sp_last");
        add_idle("sp_free");

        // Inputs 2 and 7 both request output 9 (bits 1,0,0,1); input 2 wins.
        // Input 0 addresses 9 so that its request lands exactly in the cycle busy clears.
        m = b(2) | b(7);
        add(1'b0, m,    ONES, ~m, ZERO, ONES, ONES, ZERO, "ct_a0");
        add(1'b0, ZERO, ONES, ~m, ZERO, ONES, ONES, ZERO, "ct_a1");
        add(1'b0, ZERO, ONES, ~m, ZERO, ONES, ONES, ZERO, "ct_a2");
        add(1'b0, m,    ONES, ~m, ZERO, ONES, ~b(9), b(9), "ct_a3");
        add(1'b0, b(2),        ~m, ~m,           b(9), ~b(9), ~b(9), b(9), "ct_p0");
        add(1'b0, m,           ~m, ~m,           b(9), ~b(9), ~b(9), b(9), "ct_p1");
        add(1'b0, b(7) | b(0), ~m, ~(m | b(0)),  ZERO, ~b(9), ~b(9), b(9), "ct_p2");
        add(1'b0, m,           ~m, ~b(0),        b(9), ~b(9), ONES,  b(9), "ct_last");
        add(1'b0, ZERO,  ONES,  ~b(0), ZERO, ONES, ONES, ZERO, "ct_free");
        add(1'b0, b(0),  ONES,  ~b(0), ZERO, ONES, ~b(9), b(9), "ct_regrant");
        add(1'b0, b(0),  ~b(0), ONES,  b(9), ~b(9), ONES, b(9), "ct_1bit");
        add_idle("ct_done");

        // Input 5 -> output 12 (bits 0,0,1,1); 3-cycle gap; ends with no final bit.
        add(1'b0, ZERO, ONES, ~b(5), ZERO, ONES, ONES, ZERO, "gp_a0");
        add(1'b0, ZERO, ONES, ~b(5), ZERO, ONES, ONES, ZERO, "gp_a1");
        add(1'b0, b(5), ONES, ~b(5), ZERO, ONES, ONES, ZERO, "gp_a2");
        add(1'b0, b(5), ONES, ~b(5), ZERO, ONES, ~b(12), b(12), "gp_a3");
        add(1'b0, b(5), ~b(5), ~b(5), b(12), ~b(12), ~b(12), b(12), "gp_p0");
        add(1'b0, b(5), ONES,  ~b(5), ZERO,  ONES,   ~b(12), b(12), "gp_gap0");
        add(1'b0, b(5), ONES,  ~b(5), ZERO,  ONES,   ~b(12), b(12), "gp_gap1");
        add(1'b0, b(5), ONES,  ~b(5), ZERO,  ONES,   ~b(12), b(12), "gp_gap2");
        add(1'b0, ZERO, ~b(5), ~b(5), ZERO,  ~b(12), ~b(12), b(12), "gp_p1");
        add(1'b0, b(5), ~b(5), ~b(5), b(12), ~b(12), ~b(12), b(12), "gp_p2");
        add(1'b0, ZERO, ONES,  ONES,  ZERO,  ONES,   ONES,   b(12), "gp_end");
        add_idle("gp_free");

        // Input 1 aborts after two address bits.
        add(1'b0, b(1), ONES, ~b(1), ZERO, ONES, ONES, ZERO, "ab_a0");
        add(1'b0, b(1), ONES, ~b(1), ZERO, ONES, ONES, ZERO, "ab_a1");
        add_idle("ab_gap0");
        add_idle("ab_gap1");

        // Input 1 -> output 3 (bits 1,1,0,0); reset lands mid-payload.
        add(1'b0, b(1), ONES, ~b(1), ZERO, ONES, ONES, ZERO, "rs_a0");
        add(1'b0, b(1), ONES, ~b(1), ZERO, ONES, ONES, ZERO, "rs_a1");
        add(1'b0, ZERO, ONES, ~b(1), ZERO, ONES, ONES, ZERO, "rs_a2");
        add(1'b0, ZERO, ONES, ~b(1), ZERO, ONES, ~b(3), b(3), "rs_a3");
        add(1'b0, b(1), ~b(1), ~b(1), b(3), ~b(3), ~b(3), b(3), "rs_p0");
        add(1'b1, b(1), ~b(1), ~b(1), ZERO, ONES, ONES, ZERO, "rs_reset");
        add(1'b0, b(1), ~b(1), ~b(1), ZERO, ONES, ONES, ZERO, "rs_after0");
        add(1'b0, b(1), ~b(1), ~b(1), ZERO, ONES, ONES, ZERO, "rs_after1");
        add(1'b0, b(1), ~b(1), ONES,  ZERO, ONES, ONES, ZERO, "rs_after2");
        add_idle("rs_quiet");

        for (int r = 0; r < tbl.size(); r++) begin
            apply(tbl[r]);
        end

        // All 16 inputs in parallel, input i -> output 15-i, payload (i*5+3) LSB first.
        for (int k = 0; k < AW; k++) begin
            v.rst = 1'b0; v.vn = ONES; v.fn = ZERO; v.din = ZERO;
            for (int i = 0; i < N; i++) begin
                v.din[i] = 1'(((N - 1 - i) >> k) & 1);
            end
            v.e_dout = ZERO; v.e_vn = ONES;
            v.e_fn   = (k == AW - 1) ? ZERO : ONES;
            v.e_busy = (k == AW - 1) ? ONES : ZERO;
            v.tag    = $sformatf("cc_a%0d", k);
            apply(v);
        end
        for (int k = 0; k < 4; k++) begin
            v.rst = 1'b0; v.vn = ZERO;
            v.fn  = (k == 3) ? ONES : ZERO;
            v.din = ZERO; v.e_dout = ZERO;
            for (int i = 0; i < N; i++) begin
                v.din[i]           = 1'((((i * 5 + 3) % 16) >> k) & 1);
                v.e_dout[N - 1 - i] = 1'((((i * 5 + 3) % 16) >> k) & 1);
            end
            v.e_vn   = ZERO;
            v.e_fn   = (k == 3) ? ONES : ZERO;
            v.e_busy = ONES;
            v.tag    = $sformatf("cc_p%0d", k);
            apply(v);
        end
        v.rst = 1'b0; v.din = ZERO; v.vn = ONES; v.fn = ONES;
        v.e_dout = ZERO; v.e_vn = ONES; v.e_fn = ONES; v.e_busy = ZERO; v.tag = "cc_free";
        apply(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/modport_router.md
MODPORT_ROUTER -- requirements
Module: modport_router

Interface
REQ-001 The block SHALL use parameter NPORTS, default 16, as the number of input ports and the number of output ports.
REQ-002 The block SHALL use parameter ADDR_W, default 4, as the number of serial destination-address bits per packet (clog2 of NPORTS).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all ports are listed below.
REQ-004 The block SHALL have port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port din, input, NPORTS bits: serial data, one bit per input port.
REQ-007 The block SHALL have port valid_n, input, NPORTS bits: active-low payload-bit-valid per input.
REQ-008 The block SHALL have port frame_n, input, NPORTS bits: active-low packet frame per input.
REQ-009 The block SHALL have port dout, output, NPORTS bits: serial data per output port.
REQ-010 The block SHALL have port valido_n, output, NPORTS bits: active-low data-valid per output.
REQ-011 The block SHALL have port frameo_n, output, NPORTS bits: active-low frame per output.
REQ-012 The block SHALL have port busy_state, output, NPORTS bits: high while the output port is owned by an input.

Function
REQ-013 Each input SHALL be idle until frame_n[i] is sampled low; that cycle carries address bit 0 on din[i]; the next ADDR_W-1 cycles carry bits 1..ADDR_W-1, LSB first; valid_n is ignored during address cycles.
REQ-014 If frame_n[i] is sampled high before all ADDR_W address bits are taken, the input SHALL abort to IDLE with no output effect.
REQ-015 After the last address bit, the input SHALL request output d; the grant is decided in the same cycle.
REQ-016 A request SHALL be granted only if busy_state[d] is low; among simultaneous requests for one output, the lowest input index SHALL win.
REQ-017 A losing or blocked input SHALL enter DROP, discard bits until frame_n[i] is high with valid_n[i] low, then return to IDLE; such packets are lost (senders consult busy_state).
REQ-018 On a grant, busy_state[d] SHALL rise the next cycle and frameo_n[d] SHALL go low the same cycle.
REQ-019 In PAYLOAD, each cycle with valid_n[i] low SHALL drive dout[d]=din[i] and valido_n[d]=0 exactly one cycle later; cycles with valid_n[i] high SHALL give valido_n[d]=1 and dout[d]=0 (pad/gap cycles allowed).
REQ-020 The last payload bit SHALL be the one sampled with frame_n[i] high and valid_n[i] low; it SHALL appear on dout[d] with valido_n[d]=0 and frameo_n[d]=1 one cycle later.
REQ-021 busy_state[d] SHALL clear the cycle after that last bit appears; output d is grantable to a new request in that same cycle.
REQ-022 frame_n[i] high in PAYLOAD with valid_n[i] high SHALL also end the packet (no final bit).
REQ-023 A new packet SHALL be accepted on an input the cycle after its previous packet ended.
REQ-024 Unowned outputs SHALL drive dout=0, valido_n=1, frameo_n=1.

Reset
REQ-025 While reset is high at a clock edge, all inputs SHALL go to IDLE, all ownership SHALL clear, dout=0, valido_n='1, frameo_n='1, busy_state=0.
REQ-026 Reset asserted mid-packet SHALL abort all packets with no partial output after the reset cycle.

Structure
REQ-027 Package modport_router_pkg SHALL hold NPORTS, ADDR_W and the input-state enum IDLE/ADDR/PAYLOAD/DROP.
REQ-028 One sub-module, router_in_port, SHALL hold the per-input FSM and address shift register and be instantiated NPORTS times.
REQ-029 The top SHALL hold the arbiter, the per-output owner registers and the output registers.

Verification
REQ-030 Reset check: reset held 2 cycles -> dout=0, valido_n=16'hFFFF, frameo_n=16'hFFFF, busy_state=0.
REQ-031 Single packet: input 3 sends address 4'b0101 (din 1,0,1,0), then payload 1,0,1,1 with frame_n high on the last bit -> output 5 shows frameo_n low, then dout 1,0,1,1 with valido_n low, each one cycle after the input; frameo_n[5]=1 with the last bit; busy_state[5] clears the next cycle.
REQ-032 Contention: inputs 2 and 7 complete address 9 in the same cycle -> input 2 owns output 9; input 7's packet is dropped; no corruption on dout[9].
REQ-033 Gaps: valid_n high for 3 mid-payload cycles -> valido_n[d] high for those 3 cycles; the bit count is preserved.
REQ-034 Concurrency: 16 inputs send to 16 distinct outputs (i -> 15-i) -> all payloads delivered intact in parallel.
REQ-035 Abort: frame_n high after 2 address bits, and reset asserted mid-payload -> no output activity; busy_state=0 after reset.
